instr_queue_issue: RTL and testbench

INSTR_QUEUE_ISSUE -- requirements
Module: instr_queue_issue

---
 rtl/instr_queue_issue_pkg.sv | 36 +++
 rtl/instr_queue_issue_fifo.sv | 48 ++++
 rtl/instr_queue_issue.sv | 129 ++++++++++++
 tb/tb_instr_queue_issue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_issue_pkg.sv
// instr_queue_issue_pkg: shared types, widths and helpers for the instruction queue/issue slice.
package instr_queue_issue_pkg;

    localparam int IQ_ADDR_W     = 18;
    localparam int IQ_LOG_SSW    = 3;
    localparam int IQ_CNT_W      = IQ_LOG_SSW + 1;
    localparam int IQ_MAX_COPIES = 1 << IQ_LOG_SSW;

    typedef enum logic [1:0] {
        LOAD_STORE = 2'd0,
        RAM        = 2'd1,
        ARITHMETIC = 2'd2,
        LOOP       = 2'd3
    } instr_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } iq_state_e;

    typedef struct packed {
        instr_type_e            itype;
        logic [IQ_CNT_W-1:0]    copy_count;
        logic [IQ_ADDR_W-1:0]   cache_addr;
        logic [IQ_ADDR_W-1:0]   main_mem_addr;
        logic [IQ_ADDR_W-1:0]   d_cache_addr;
        logic [IQ_ADDR_W-1:0]   d_main_mem_addr;
    } iq_entry_t;

    // A zero copy count still issues once; anything beyond the superscalar width is clamped.
    function automatic logic [IQ_CNT_W-1:0] eff_count(input logic [IQ_CNT_W-1:0] c);
        return (c == '0) ? IQ_CNT_W'(1)
             : (c > IQ_CNT_W'(IQ_MAX_COPIES)) ? IQ_CNT_W'(IQ_MAX_COPIES) : c;
    endfunction

endpackage

// File: rtl/instr_queue_issue_fifo.sv
// instr_fifo: synchronous circular FIFO of queue entries with occupancy count, full and empty flags.
module instr_fifo
    import instr_queue_issue_pkg::*;
#(
    parameter int LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  iq_entry_t            din_i,
    output iq_entry_t            dout_o,
    output logic [LOG_DEPTH:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    iq_entry_t              mem_q [DEPTH];
    logic [LOG_DEPTH-1:0]   wr_q, rd_q;
    logic [LOG_DEPTH:0]     cnt_q;
    logic                   do_push, do_pop;

    assign full_o  = cnt_q == (LOG_DEPTH+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    // Full comes from the registered count, so a same-cycle pop never frees room for a push.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + LOG_DEPTH'(1);
            if (do_pop)  rd_q <= rd_q + LOG_DEPTH'(1);
            cnt_q <= cnt_q + (LOG_DEPTH+1)'(do_push) - (LOG_DEPTH+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_queue_issue.sv
// instr_queue_issue: queues instruction entries and expands each into copy_count issued copies
// with per-copy address strides, handshaked with issue_valid/issue_ready.
module instr_queue_issue
    import instr_queue_issue_pkg::*;
#(
    parameter int LOG_DEPTH             = 3,
    parameter int ADDR_W                = IQ_ADDR_W,
    parameter int LOG_SUPERSCALAR_WIDTH = IQ_LOG_SSW
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               queue_we,
    input  logic [1:0]                         queue_instr_type,
    input  logic [ADDR_W-1:0]                  cache_addr,
    input  logic [ADDR_W-1:0]                  main_mem_addr,
    input  logic [ADDR_W-1:0]                  d_cache_addr,
    input  logic [ADDR_W-1:0]                  d_main_mem_addr,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]     copy_count,
    output logic                               queue_full,
    output logic [LOG_DEPTH:0]                 queue_count,
    output logic                               overflow,
    output logic                               issue_valid,
    input  logic                               issue_ready,
    output logic [1:0]                         issue_instr_type,
    output logic [ADDR_W-1:0]                  issue_cache_addr,
    output logic [ADDR_W-1:0]                  issue_main_mem_addr,
    output logic [LOG_SUPERSCALAR_WIDTH-1:0]   issue_copy_idx,
    output logic                               issue_last
);
    iq_entry_t                          push_e, head;
    logic                               pop, empty;
    iq_state_e                          state_q, state_d;
    instr_type_e                        type_q, type_d;
    logic [LOG_SUPERSCALAR_WIDTH:0]     cnt_q, cnt_d, idx_inc;
    logic [LOG_SUPERSCALAR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]                  cache_q, cache_d, mem_q, mem_d;
    logic [ADDR_W-1:0]                  dc_q, dc_d, dm_q, dm_d;
    logic                               overflow_q;

    assign push_e = '{
        itype:           instr_type_e'(queue_instr_type),
        copy_count:      copy_count,
        cache_addr:      cache_addr,
        main_mem_addr:   main_mem_addr,
        d_cache_addr:    d_cache_addr,
        d_main_mem_addr: d_main_mem_addr
    };

    instr_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (queue_we),
        .pop_i   (pop),
        .din_i   (push_e),
        .dout_o  (head),
        .count_o (queue_count),
        .full_o  (queue_full),
        .empty_o (empty)
    );

    assign idx_inc             = {1'b0, idx_q} + (LOG_SUPERSCALAR_WIDTH+1)'(1);
    assign issue_valid         = state_q == ISSUE;
    assign issue_last          = issue_valid && (idx_inc >= cnt_q);
    assign issue_instr_type    = type_q;
    assign issue_cache_addr    = cache_q;
    assign issue_main_mem_addr = mem_q;
    assign issue_copy_idx      = idx_q;
    assign overflow            = overflow_q;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cache_d = cache_q;
        mem_d   = mem_q;
        dc_d    = dc_q;
        dm_d    = dm_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            pop = !empty;
        end else if (issue_ready) begin
            if (issue_last) begin
                pop     = !empty;
                state_d = empty ? IDLE : ISSUE;
            end else begin
                idx_d   = idx_q + LOG_SUPERSCALAR_WIDTH'(1);
                cache_d = cache_q + dc_q;
                mem_d   = mem_q + dm_q;
            end
        end
        // Loading the head on the same edge the last copy retires avoids an issue bubble.
        if (pop) begin
            state_d = ISSUE;
            type_d  = head.itype;
            cnt_d   = eff_count(head.copy_count);
            idx_d   = '0;
            cache_d = head.cache_addr;
            mem_d   = head.main_mem_addr;
            dc_d    = head.d_cache_addr;
            dm_d    = head.d_main_mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            type_q     <= LOAD_STORE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cache_q    <= '0;
            mem_q      <= '0;
            dc_q       <= '0;
            dm_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cache_q    <= cache_d;
            mem_q      <= mem_d;
            dc_q       <= dc_d;
            dm_q       <= dm_d;
            overflow_q <= overflow_q || (queue_we && queue_full);
        end
    end

endmodule

// File: tb/tb_instr_queue_issue.sv
// tb_instr_queue_issue: directed self-checking bench for instr_queue_issue.
module tb_instr_queue_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic        queue_we;
    logic [1:0]  queue_instr_type;
    logic [17:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic [3:0]  copy_count;
    logic        queue_full;
    logic [3:0]  queue_count;
    logic        overflow;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_instr_type;
    logic [17:0] issue_cache_addr, issue_main_mem_addr;
    logic [2:0]  issue_copy_idx;
    logic        issue_last;
    int          errors = 0;
    int          checks = 0;

    instr_queue_issue dut (
        .clk                 (clk),
        .reset               (reset),
        .queue_we            (queue_we),
        .queue_instr_type    (queue_instr_type),
        .cache_addr          (cache_addr),
        .main_mem_addr       (main_mem_addr),
        .d_cache_addr        (d_cache_addr),
        .d_main_mem_addr     (d_main_mem_addr),
        .copy_count          (copy_count),
        .queue_full          (queue_full),
        .queue_count         (queue_count),
        .overflow            (overflow),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_instr_type    (issue_instr_type),
        .issue_cache_addr    (issue_cache_addr),
        .issue_main_mem_addr (issue_main_mem_addr),
        .issue_copy_idx      (issue_copy_idx),
        .issue_last          (issue_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_entry(input logic [1:0] t, input logic [17:0] ca, input logic [17:0] ma,
                             input logic [17:0] dca, input logic [17:0] dma, input logic [3:0] cc);
        queue_instr_type = t;
        cache_addr       = ca;
        main_mem_addr    = ma;
        d_cache_addr     = dca;
        d_main_mem_addr  = dma;
        copy_count       = cc;
    endtask

    task automatic chk_issue(input string tag, input logic v, input logic [17:0] ca,
                             input logic [2:0] idx, input logic last);
        chk({tag, ".valid"}, 32'(issue_valid), 32'(v));
        chk({tag, ".cache"}, 32'(issue_cache_addr), 32'(ca));
        chk({tag, ".idx"},   32'(issue_copy_idx), 32'(idx));
        chk({tag, ".last"},  32'(issue_last), 32'(last));
    endtask

    initial begin
        reset = 1'b1;
        queue_we = 1'b0;
        issue_ready = 1'b1;
        set_entry(2'd0, 18'd0, 18'd0, 18'd0, 18'd0, 4'd0);
        step();
        step();
        reset = 1'b0;
        chk("rst.valid", 32'(issue_valid), 0);
        chk("rst.count", 32'(queue_count), 0);
        chk("rst.full", 32'(queue_full), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.cache", 32'(issue_cache_addr), 0);
        chk("rst.mem", 32'(issue_main_mem_addr), 0);
        chk("rst.type", 32'(issue_instr_type), 0);
        chk("rst.last", 32'(issue_last), 0);

        // 3-copy RAM entry with strides
        set_entry(2'd1, 18'd100, 18'd2000, 18'd4, 18'd16, 4'd3);
        queue_we = 1'b1;
        step();
        queue_we = 1'b0;
        chk("ram.e0.valid", 32'(issue_valid), 0);
        chk("ram.e0.count", 32'(queue_count), 1);
        step();
        chk_issue("ram.c0", 1'b1, 18'd100, 3'd0, 1'b0);
        chk("ram.c0.mem", 32'(issue_main_mem_addr), 2000);
        chk("ram.c0.type", 32'(issue_instr_type), 1);
        chk("ram.c0.count", 32'(queue_count), 0);
        step();
        chk_issue("ram.c1", 1'b1, 18'd104, 3'd1, 1'b0);
        chk("ram.c1.mem", 32'(issue_main_mem_addr), 2016);
        step();
        chk_issue("ram.c2", 1'b1, 18'd108, 3'd2, 1'b1);
        chk("ram.c2.mem", 32'(issue_main_mem_addr), 2032);
        step();
        chk("ram.done.valid", 32'(issue_valid), 0);

        // back-to-back single-copy entries; copy_count 0 acts as 1
        set_entry(2'd2, 18'd10, 18'd11, 18'd1, 18'd1, 4'd0);
        queue_we = 1'b1;
        step();
        set_entry(2'd3, 18'd20, 18'd21, 18'd1, 18'd1, 4'd1);
        step();
        queue_we = 1'b0;
        chk_issue("b2b.a", 1'b1, 18'd10, 3'd0, 1'b1);
        chk("b2b.a.count", 32'(queue_count), 1);
        step();
        chk_issue("b2b.b", 1'b1, 18'd20, 3'd0, 1'b1);
        chk("b2b.b.type", 32'(issue_instr_type), 3);
        chk("b2b.b.count", 32'(queue_count), 0);
        step();
        chk("b2b.done.valid", 32'(issue_valid), 0);

        // address wrap modulo 2^18
        set_entry(2'd0, 18'd262142, 18'd0, 18'd3, 18'd0, 4'd2);
        queue_we = 1'b1;
        step();
        queue_we = 1'b0;
        step();
        chk_issue("wrap.c0", 1'b1, 18'd262142, 3'd0, 1'b0);
        step();
        chk_issue("wrap.c1", 1'b1, 18'd1, 3'd1, 1'b1);
        step();
        chk("wrap.done.valid", 32'(issue_valid), 0);

        // issue_ready pattern 1,0,0,1 on a 4-copy entry
        set_entry(2'd1, 18'd64, 18'd5, 18'd1, 18'd0, 4'd4);
        queue_we = 1'b1;
        step();
        queue_we = 1'b0;
        step();
        chk_issue("stall.c0", 1'b1, 18'd64, 3'd0, 1'b0);
        step();
        chk_issue("stall.c1", 1'b1, 18'd65, 3'd1, 1'b0);
        issue_ready = 1'b0;
        step();
        chk_issue("stall.h1", 1'b1, 18'd65, 3'd1, 1'b0);
        chk("stall.h1.mem", 32'(issue_main_mem_addr), 5);
        step();
        chk_issue("stall.h2", 1'b1, 18'd65, 3'd1, 1'b0);
        issue_ready = 1'b1;
        step();
        chk_issue("stall.c2", 1'b1, 18'd66, 3'd2, 1'b0);
        step();
        chk_issue("stall.c3", 1'b1, 18'd67, 3'd3, 1'b1);
        step();
        chk("stall.done.valid", 32'(issue_valid), 0);

        // copy_count above 8 is clamped to 8 copies
        set_entry(2'd0, 18'd0, 18'd0, 18'd1, 18'd0, 4'd15);
        queue_we = 1'b1;
        step();
        queue_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_issue($sformatf("clamp.c%0d", i), 1'b1, 18'(i), 3'(i), i == 7);
        end
        step();
        chk("clamp.done.valid", 32'(issue_valid), 0);

        // fill with issue stalled: 1 in issue register + 8 queued, 10th push dropped
        issue_ready = 1'b0;
        queue_we = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_entry(2'd0, 18'(i + 1), 18'd0, 18'd0, 18'd0, 4'd1);
            step();
        end
        chk("fill.count", 32'(queue_count), 8);
        chk("fill.full", 32'(queue_full), 1);
        chk("fill.ovf0", 32'(overflow), 0);
        chk("fill.head", 32'(issue_cache_addr), 1);
        set_entry(2'd0, 18'd99, 18'd0, 18'd0, 18'd0, 4'd1);
        issue_ready = 1'b1;
        step();
        queue_we = 1'b0;
        chk("ovf.set", 32'(overflow), 1);
        chk("ovf.count", 32'(queue_count), 7);
        chk("ovf.next", 32'(issue_cache_addr), 2);
        for (int i = 3; i <= 9; i++) step();
        chk("ovf.lastq", 32'(issue_cache_addr), 9);
        step();
        chk("ovf.drop.valid", 32'(issue_valid), 0);
        chk("ovf.sticky", 32'(overflow), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ovf.rst", 32'(overflow), 0);
        chk("ovf.rst.full", 32'(queue_full), 0);

        // reset during copy 2 of 5 with 3 queued entries
        set_entry(2'd2, 18'd500, 18'd0, 18'd1, 18'd0, 4'd5);
        queue_we = 1'b1;
        step();
        set_entry(2'd0, 18'd700, 18'd0, 18'd0, 18'd0, 4'd1);
        step();
        step();
        step();
        queue_we = 1'b0;
        chk_issue("mid.c2", 1'b1, 18'd502, 3'd2, 1'b0);
        chk("mid.count", 32'(queue_count), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_issue("mid.rst", 1'b0, 18'd0, 3'd0, 1'b0);
        chk("mid.rst.count", 32'(queue_count), 0);
        chk("mid.rst.ovf", 32'(overflow), 0);
        step();
        step();
        chk("mid.after.valid", 32'(issue_valid), 0);
        chk("mid.after.count", 32'(queue_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
